// File: rtl/tcdm_bank_responder.sv
// TCDM bank target: single-ported word memory, fixed-latency responses, saturating access counters.
// Define TCDM_BANK_PARITY_EN to add per-word even parity with par_inj_i / par_err_o.
module tcdm_bank_responder #(
  parameter int unsigned NumWords    = 1024,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned RespLat     = 1,
  parameter bit          WriteRespOn = 1'b1,
  parameter int unsigned CntWidth    = 16,
  localparam int unsigned AddrWidth  = $clog2(NumWords)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [AddrWidth-1:0] add_i,
  input  logic                 wen_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 vld_o,
  input  logic                 stall_i,
`ifdef TCDM_BANK_PARITY_EN
  input  logic                 par_inj_i,
  output logic                 par_err_o,
`endif
  output logic [CntWidth-1:0]  rd_cnt_o,
  output logic [CntWidth-1:0]  wr_cnt_o,
  output logic [CntWidth-1:0]  stall_cnt_o
);

  typedef struct packed {
    logic                 vld;
    logic                 rd;
`ifdef TCDM_BANK_PARITY_EN
    logic                 perr;
`endif
    logic [DataWidth-1:0] data;
  } stage_t;

  logic [DataWidth-1:0] mem_q [NumWords];
`ifdef TCDM_BANK_PARITY_EN
  logic                 par_q [NumWords];
`endif
  stage_t               pipe_q [RespLat];
  stage_t               pipe_d [RespLat];
  logic [CntWidth-1:0]  rd_cnt_q, wr_cnt_q, stall_cnt_q;
  logic [CntWidth-1:0]  rd_cnt_d, wr_cnt_d, stall_cnt_d;
  logic                 accept;

  assign gnt_o  = req_i & ~stall_i & ~rst_i;
  assign accept = gnt_o;

  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] cnt,
                                                  input logic              en);
    return (en && (cnt != '1)) ? cnt + 1'b1 : cnt;
  endfunction

  // NOTE: the array has no reset; like the SRAM it replaces, contents are undefined until written.
  always_ff @(posedge clk_i) begin
    if (accept && wen_i) begin
      mem_q[add_i] <= wdata_i;
`ifdef TCDM_BANK_PARITY_EN
      par_q[add_i] <= (^wdata_i) ^ par_inj_i;
`endif
    end
  end

  // Data fields only load on reads, so the last stage holds the previous read data across writes.
  always_comb begin
    // NOTE: default every comb output first so no path is left unassigned and infers a latch.
    pipe_d        = pipe_q;
    pipe_d[0].vld = accept;
    pipe_d[0].rd  = accept & ~wen_i;
    if (accept && !wen_i) pipe_d[0].data = mem_q[add_i];
`ifdef TCDM_BANK_PARITY_EN
    pipe_d[0].perr = accept & ~wen_i & (^{mem_q[add_i], par_q[add_i]});
`endif
    for (int i = 1; i < RespLat; i++) begin
      pipe_d[i].vld = pipe_q[i-1].vld;
      pipe_d[i].rd  = pipe_q[i-1].rd;
      if (pipe_q[i-1].rd) pipe_d[i].data = pipe_q[i-1].data;
`ifdef TCDM_BANK_PARITY_EN
      pipe_d[i].perr = pipe_q[i-1].perr;
`endif
    end
  end

  always_comb begin
    rd_cnt_d    = sat_inc(rd_cnt_q, accept & ~wen_i);
    wr_cnt_d    = sat_inc(wr_cnt_q, accept & wen_i);
    stall_cnt_d = sat_inc(stall_cnt_q, req_i & stall_i);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_q      <= '{default: '0};
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      pipe_q      <= pipe_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Store responses travel down the pipeline but are only presented when WriteRespOn is set.
  assign vld_o       = pipe_q[RespLat-1].vld & (pipe_q[RespLat-1].rd | WriteRespOn);
  assign rdata_o     = pipe_q[RespLat-1].data;
`ifdef TCDM_BANK_PARITY_EN
  assign par_err_o   = pipe_q[RespLat-1].vld & pipe_q[RespLat-1].perr;
`endif
  assign rd_cnt_o    = rd_cnt_q;
  assign wr_cnt_o    = wr_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Directed bench for tcdm_bank_responder: instance A (RespLat=1, write responses, 4-bit counters)
// and instance B (RespLat=3, no write responses, 16-bit counters); parity steps under TCDM_BANK_PARITY_EN.
module tb_tcdm_bank_responder;
  localparam int AW = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          a_req, a_gnt, a_wen, a_vld, a_stall;
  logic [AW-1:0] a_add;
  logic [DW-1:0] a_wdata, a_rdata;
  logic [3:0]    a_rd_cnt, a_wr_cnt, a_stall_cnt;
  logic          b_req, b_gnt, b_wen, b_vld, b_stall;
  logic [AW-1:0] b_add;
  logic [DW-1:0] b_wdata, b_rdata;
  logic [15:0]   b_rd_cnt, b_wr_cnt, b_stall_cnt;
`ifdef TCDM_BANK_PARITY_EN
  logic a_par_inj, a_par_err, b_par_inj, b_par_err;
`endif

  int tests = 0;
  int fails = 0;

  tcdm_bank_responder #(.NumWords(16), .DataWidth(DW), .RespLat(1), .WriteRespOn(1'b1),
                        .CntWidth(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(a_req), .gnt_o(a_gnt), .add_i(a_add), .wen_i(a_wen),
    .wdata_i(a_wdata), .rdata_o(a_rdata), .vld_o(a_vld), .stall_i(a_stall),
`ifdef TCDM_BANK_PARITY_EN
    .par_inj_i(a_par_inj), .par_err_o(a_par_err),
`endif
    .rd_cnt_o(a_rd_cnt), .wr_cnt_o(a_wr_cnt), .stall_cnt_o(a_stall_cnt)
  );

  tcdm_bank_responder #(.NumWords(16), .DataWidth(DW), .RespLat(3), .WriteRespOn(1'b0),
                        .CntWidth(16)) dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(b_req), .gnt_o(b_gnt), .add_i(b_add), .wen_i(b_wen),
    .wdata_i(b_wdata), .rdata_o(b_rdata), .vld_o(b_vld), .stall_i(b_stall),
`ifdef TCDM_BANK_PARITY_EN
    .par_inj_i(b_par_inj), .par_err_o(b_par_err),
`endif
    .rd_cnt_o(b_rd_cnt), .wr_cnt_o(b_wr_cnt), .stall_cnt_o(b_stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic req, input logic wen, input logic [AW-1:0] add,
                         input logic [DW-1:0] wd);
    a_req = req; a_wen = wen; a_add = add; a_wdata = wd;
  endtask

  task automatic b_drive(input logic req, input logic wen, input logic [AW-1:0] add,
                         input logic [DW-1:0] wd);
    b_req = req; b_wen = wen; b_add = add; b_wdata = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with a store request present: no grant, outputs cleared.
    rst = 1'b1; a_stall = 1'b0; b_stall = 1'b0;
`ifdef TCDM_BANK_PARITY_EN
    a_par_inj = 1'b0; b_par_inj = 1'b0;
`endif
    a_drive(1'b1, 1'b1, 4'd5, 32'h1234);
    b_drive(1'b0, 1'b0, 4'd0, 32'h0);
    #1;
    check("a_gnt_in_reset", 64'(a_gnt), 64'(0));
    cyc(); cyc();
    check("a_vld_reset", 64'(a_vld), 64'(0));
    check("a_rdata_reset", 64'(a_rdata), 64'(0));
    check("a_rd_cnt_reset", 64'(a_rd_cnt), 64'(0));
    check("a_wr_cnt_reset", 64'(a_wr_cnt), 64'(0));
    check("b_vld_reset", 64'(b_vld), 64'(0));
    rst = 1'b0;

    // Store then load, RespLat=1.
    a_drive(1'b1, 1'b1, 4'd5, 32'hDEADBEEF);
    #1 check("a_gnt_store", 64'(a_gnt), 64'(1));
    cyc();
    check("a_vld_wr_resp", 64'(a_vld), 64'(1));
    check("a_rdata_hold_wr", 64'(a_rdata), 64'(0));
    a_drive(1'b1, 1'b0, 4'd5, 32'h0);
    #1 check("a_gnt_load", 64'(a_gnt), 64'(1));
    cyc();
    check("a_vld_rd_resp", 64'(a_vld), 64'(1));
    check("a_rdata_raw", 64'(a_rdata), 64'(32'hDEADBEEF));
    check("a_wr_cnt_1", 64'(a_wr_cnt), 64'(1));
    check("a_rd_cnt_1", 64'(a_rd_cnt), 64'(1));
    a_drive(1'b0, 1'b0, 4'd0, 32'h0);
    cyc();
    check("a_vld_idle", 64'(a_vld), 64'(0));
    check("a_rdata_hold_idle", 64'(a_rdata), 64'(32'hDEADBEEF));

    // Stall for 4 cycles with a store held: no grant, no write.
    a_drive(1'b1, 1'b1, 4'd3, 32'hAAAA);
    cyc();
    a_drive(1'b1, 1'b1, 4'd3, 32'hBBBB);
    a_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check("a_gnt_stalled", 64'(a_gnt), 64'(0));
      cyc();
    end
    check("a_stall_cnt_4", 64'(a_stall_cnt), 64'(4));
    a_stall = 1'b0;
    a_drive(1'b1, 1'b0, 4'd3, 32'h0);
    #1 check("a_gnt_resume", 64'(a_gnt), 64'(1));
    cyc();
    check("a_vld_after_stall", 64'(a_vld), 64'(1));
    check("a_rdata_no_stall_write", 64'(a_rdata), 64'(32'hAAAA));
    check("a_wr_cnt_2", 64'(a_wr_cnt), 64'(2));
    check("a_rd_cnt_2", 64'(a_rd_cnt), 64'(2));

    // 20 back-to-back loads: 4-bit read counter saturates at 15.
    for (int i = 0; i < 20; i++) begin
      a_drive(1'b1, 1'b0, 4'(i), 32'h0);
      cyc();
      check("a_vld_b2b", 64'(a_vld), 64'(1));
      if (i == 12) check("a_rd_cnt_reach15", 64'(a_rd_cnt), 64'(15));
    end
    check("a_rd_cnt_sat", 64'(a_rd_cnt), 64'(15));
    check("a_rdata_last_b2b", 64'(a_rdata), 64'(32'hAAAA));
    check("a_wr_cnt_still2", 64'(a_wr_cnt), 64'(2));
    a_drive(1'b0, 1'b0, 4'd0, 32'h0);

`ifdef TCDM_BANK_PARITY_EN
    // Injected parity error is flagged on the read only.
    a_par_inj = 1'b1;
    a_drive(1'b1, 1'b1, 4'd9, 32'h1);
    cyc();
    check("a_par_wr_resp_clean", 64'(a_par_err), 64'(0));
    a_par_inj = 1'b0;
    a_drive(1'b1, 1'b0, 4'd9, 32'h0);
    cyc();
    check("a_par_vld", 64'(a_vld), 64'(1));
    check("a_par_err_inj", 64'(a_par_err), 64'(1));
    a_drive(1'b1, 1'b1, 4'd9, 32'h1);
    cyc();
    a_drive(1'b1, 1'b0, 4'd9, 32'h0);
    cyc();
    check("a_par_err_clean", 64'(a_par_err), 64'(0));
    check("a_par_rdata", 64'(a_rdata), 64'(1));
    a_drive(1'b0, 1'b0, 4'd0, 32'h0);
    cyc();
    check("a_par_err_idle", 64'(a_par_err), 64'(0));
`endif

    // Instance B: preload addr*3, no write responses with WriteRespOn=0.
    for (int i = 0; i < 8; i++) begin
      b_drive(1'b1, 1'b1, 4'(i), 32'(i * 3));
      cyc();
      check("b_no_wr_resp", 64'(b_vld), 64'(0));
    end
    // 8 consecutive loads, RespLat=3.
    for (int k = 0; k < 11; k++) begin
      if (k < 8) b_drive(1'b1, 1'b0, 4'(k), 32'h0);
      else       b_drive(1'b0, 1'b0, 4'd0, 32'h0);
      #1 check("b_gnt_burst", 64'(b_gnt), 64'(k < 8));
      cyc();
      check("b_vld_burst", 64'(b_vld), 64'(k >= 2 && k < 10));
      check("b_rdata_burst", 64'(b_rdata), 64'(k < 2 ? 0 : (k < 10 ? (k - 2) * 3 : 21)));
    end
    check("b_wr_cnt_8", 64'(b_wr_cnt), 64'(8));
    check("b_rd_cnt_8", 64'(b_rd_cnt), 64'(8));

    // Stall mid-burst: accepted loads still complete on schedule.
    b_drive(1'b1, 1'b0, 4'd1, 32'h0);
    cyc();
    b_drive(1'b1, 1'b0, 4'd2, 32'h0);
    cyc();
    b_stall = 1'b1;
    b_drive(1'b1, 1'b0, 4'd4, 32'h0);
    #1 check("b_gnt_stall", 64'(b_gnt), 64'(0));
    cyc();
    check("b_vld_inflight1", 64'(b_vld), 64'(1));
    check("b_rdata_inflight1", 64'(b_rdata), 64'(3));
    b_stall = 1'b0;
    b_drive(1'b0, 1'b0, 4'd0, 32'h0);
    cyc();
    check("b_vld_inflight2", 64'(b_vld), 64'(1));
    check("b_rdata_inflight2", 64'(b_rdata), 64'(6));
    cyc();
    check("b_vld_stalled_none", 64'(b_vld), 64'(0));
    check("b_stall_cnt_1", 64'(b_stall_cnt), 64'(1));
    check("b_rd_cnt_10", 64'(b_rd_cnt), 64'(10));

    // Reset with two loads in flight and a store request pending.
    b_drive(1'b1, 1'b0, 4'd7, 32'h0);
    cyc();
    b_drive(1'b1, 1'b0, 4'd6, 32'h0);
    cyc();
    rst = 1'b1;
    b_drive(1'b1, 1'b1, 4'd1, 32'h22);
    #1 check("b_gnt_in_reset", 64'(b_gnt), 64'(0));
    cyc();
    check("b_vld_flushed", 64'(b_vld), 64'(0));
    check("b_rdata_reset", 64'(b_rdata), 64'(0));
    check("b_rd_cnt_reset", 64'(b_rd_cnt), 64'(0));
    check("b_wr_cnt_reset", 64'(b_wr_cnt), 64'(0));
    check("b_stall_cnt_reset", 64'(b_stall_cnt), 64'(0));
    check("a_rd_cnt_reset2", 64'(a_rd_cnt), 64'(0));
    rst = 1'b0;
    b_drive(1'b0, 1'b0, 4'd0, 32'h0);
    cyc();
    check("b_vld_post_rst1", 64'(b_vld), 64'(0));
    cyc();
    check("b_vld_post_rst2", 64'(b_vld), 64'(0));
    b_drive(1'b1, 1'b0, 4'd1, 32'h0);
    cyc();
    b_drive(1'b0, 1'b0, 4'd0, 32'h0);
    cyc(); cyc();
    check("b_vld_after_rst_load", 64'(b_vld), 64'(1));
    check("b_no_write_in_reset", 64'(b_rdata), 64'(3));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
